multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath/register/address width (minimum 32).
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register index width (5 = 32 registers, 4 = 16 registers, RV32E-style).
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Parameter RET_WIDTH, default 32, retired-instruction counter width.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 mem_req  out  1  memory transaction request.
REQ-008 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-009 mem_addr  out  DATA_WIDTH  byte address, word-aligned.
REQ-010 mem_wdata  out  DATA_WIDTH  store data.
REQ-011 mem_rdata  in  DATA_WIDTH  read data, valid in the mem_ready cycle.
REQ-012 mem_ready  in  1  transaction completes at the edge where mem_req=1 and mem_ready=1.
REQ-013 a0  out  DATA_WIDTH  registered copy of register x10.
REQ-014 halted  out  1  core stopped in HALT.
REQ-015 retired  out  RET_WIDTH  count of completed instructions.

Function
REQ-016 Supported instructions: ADDI, ADD, SUB, LUI, LW, SW, BEQ, BNE (RV32I encodings; funct3/funct7 fully decoded).
REQ-017 Any other encoding, or a register index >= 2^REG_ADDR_WIDTH, SHALL be illegal and SHALL cause a transition to HALT.
REQ-018 Register x0 SHALL read as 0; writes to x0 are discarded.
REQ-019 FSM states: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=PC; hold until mem_ready; then latch IR and go to DECODE.
REQ-021 DECODE: read rs1/rs2 into operand registers and form the sign-extended immediate (I/S/B/U formats); go to EXECUTE, or to HALT if illegal.
REQ-022 EXECUTE: ALU ops and LUI -> WB. Branch -> FETCH with PC = PC+immB if taken, else PC+4. LW/SW compute address rs1+immI/immS -> MEM.
REQ-023 Misaligned LW/SW address (addr[1:0]!=0) SHALL go to HALT from EXECUTE, with no memory request issued.
REQ-024 MEM: mem_req=1, mem_addr=address, mem_we=1 and mem_wdata=rs2 for SW; hold until mem_ready. LW -> WB with rdata latched. SW -> FETCH with PC+4.
REQ-025 WB: write rd, PC += 4; go to FETCH.
REQ-026 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable from mem_req assertion until completion; mem_ready SHALL be ignored while mem_req=0.
REQ-027 Arithmetic is modulo 2^DATA_WIDTH; PC wraps silently.
REQ-028 retired SHALL increment by 1 on each instruction completion (WB exit, branch EXECUTE exit, SW MEM exit) and SHALL wrap at 2^RET_WIDTH.
REQ-029 a0 SHALL update in the cycle after any write to x10.
REQ-030 Latency with zero-wait memory: ALU/LUI 4 cycles, branch 3 cycles, LW 5 cycles, SW 4 cycles; each memory wait cycle adds 1 cycle.
REQ-031 HALT: halted=1 and mem_req=0; HALT is left only by rst. The illegal instruction is not counted in retired.

Reset
REQ-032 While rst=1 at an edge: state=FETCH, PC=RESET_PC, all registers=0, a0=0, retired=0, halted=0, and mem_req=0 from the next cycle.
REQ-033 A reset during an outstanding transaction SHALL abandon it; no register, PC or counter update from that transaction occurs.

Verification
REQ-034 Zero-wait program `addi x10,x0,5; addi x10,x10,-7` -> a0=5 then a0=0xFFFFFFFE; retired=2 after 8 cycles.
REQ-035 Loop `addi x1,x0,3; L: addi x1,x1,-1; bne x1,x0,L` -> 3 loop iterations, then falls through; retired=7.
REQ-036 `sw x10,8(x0)` then `lw x11,8(x0)` with 2-cycle mem_ready delay -> mem_we=1, addr=8, wdata=a0; x11 matches; address/data stable through wait cycles.
REQ-037 `lw` at address 6, or opcode 0x0000007F -> halted=1, mem_req=0 thereafter, retired unchanged.
REQ-038 rst pulsed during a stalled FETCH -> next cycle mem_req=0, then fetch at RESET_PC, a0=0, retired=0.

Source files
------------

// File: rtl/multicycle_core.sv
// multicycle_core: multicycle RV32I-subset core (ADDI/ADD/SUB/LUI/LW/SW/BEQ/BNE) with a req/ready memory port.
module multicycle_core #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REG_ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    RET_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] a0,
    output logic                  halted,
    output logic [RET_WIDTH-1:0]  retired
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
    localparam int NREGS = 2 ** REG_ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    state_t                    state_q;
    logic [DATA_WIDTH-1:0]     regs_q [NREGS];
    logic [DATA_WIDTH-1:0]     pc_q, op1_q, op2_q, imm_q, res_q, a0_q;
    logic [DATA_WIDTH-1:0]     mem_addr_q, mem_wdata_q;
    logic [31:0]               ir_q;
    logic [RET_WIDTH-1:0]      retired_q;
    logic                      halted_q, mem_req_q, mem_we_q;

    logic [6:0]                opcode, funct7;
    logic [2:0]                funct3;
    logic [4:0]                rd, rs1, rs2;
    logic [REG_ADDR_WIDTH-1:0] rd_idx, rs1_idx, rs2_idx;
    logic is_addi, is_add, is_sub, is_lui, is_lw, is_sw, is_beq, is_bne, is_br;
    logic uses_rd, uses_rs1, uses_rs2, bad_reg, legal, taken;
    logic [DATA_WIDTH-1:0]     imm_i, imm_s, imm_b, imm_u, imm_d, alu_d, addr_d, pc4_d, br_pc_d;

    assign opcode  = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign funct3  = ir_q[14:12];
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign funct7  = ir_q[31:25];
    assign rd_idx  = rd[REG_ADDR_WIDTH-1:0];
    assign rs1_idx = rs1[REG_ADDR_WIDTH-1:0];
    assign rs2_idx = rs2[REG_ADDR_WIDTH-1:0];

    assign is_addi = opcode == 7'h13 && funct3 == 3'b000;
    assign is_add  = opcode == 7'h33 && funct3 == 3'b000 && funct7 == 7'h00;
    assign is_sub  = opcode == 7'h33 && funct3 == 3'b000 && funct7 == 7'h20;
    assign is_lui  = opcode == 7'h37;
    assign is_lw   = opcode == 7'h03 && funct3 == 3'b010;
    assign is_sw   = opcode == 7'h23 && funct3 == 3'b010;
    assign is_beq  = opcode == 7'h63 && funct3 == 3'b000;
    assign is_bne  = opcode == 7'h63 && funct3 == 3'b001;
    assign is_br   = is_beq || is_bne;

    // Register fields only matter for the formats that actually use them.
    assign uses_rd  = is_addi || is_add || is_sub || is_lui || is_lw;
    assign uses_rs1 = is_addi || is_add || is_sub || is_lw || is_sw || is_br;
    assign uses_rs2 = is_add || is_sub || is_sw || is_br;
    assign bad_reg  = (uses_rd && (rd >> REG_ADDR_WIDTH) != 5'd0)
                   || (uses_rs1 && (rs1 >> REG_ADDR_WIDTH) != 5'd0)
                   || (uses_rs2 && (rs2 >> REG_ADDR_WIDTH) != 5'd0);
    assign legal    = (uses_rd || is_sw || is_br) && !bad_reg;

    assign imm_i   = DATA_WIDTH'($signed(ir_q[31:20]));
    assign imm_s   = DATA_WIDTH'($signed({ir_q[31:25], ir_q[11:7]}));
    assign imm_b   = DATA_WIDTH'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
    assign imm_u   = DATA_WIDTH'($signed({ir_q[31:12], 12'b0}));
    assign imm_d   = is_lui ? imm_u : is_sw ? imm_s : is_br ? imm_b : imm_i;

    assign addr_d  = op1_q + imm_q;
    assign alu_d   = is_lui ? imm_q : is_sub ? op1_q - op2_q : is_add ? op1_q + op2_q : addr_d;
    assign taken   = is_beq ? op1_q == op2_q : op1_q != op2_q;
    assign pc4_d   = pc_q + FOUR;
    assign br_pc_d = taken ? pc_q + imm_q : pc4_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            imm_q       <= '0;
            res_q       <= '0;
            a0_q        <= '0;
            retired_q   <= '0;
            halted_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                // Transitions into FETCH/MEM raise the request together with the state, so it
                // is registered and stable; only the first fetch after reset spends an idle cycle.
                FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        ir_q      <= mem_rdata[31:0];
                        mem_req_q <= 1'b0;
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    op1_q    <= regs_q[rs1_idx];
                    op2_q    <= regs_q[rs2_idx];
                    imm_q    <= imm_d;
                    halted_q <= !legal;
                    state_q  <= legal ? EXECUTE : HALT;
                end
                EXECUTE: begin
                    if (is_br) begin
                        pc_q       <= br_pc_d;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= br_pc_d;
                        retired_q  <= retired_q + RET_WIDTH'(1);
                        state_q    <= FETCH;
                    end else if (is_lw || is_sw) begin
                        if (addr_d[1:0] != 2'b00) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_sw;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= op2_q;
                            state_q     <= MEM;
                        end
                    end else begin
                        res_q   <= alu_d;
                        state_q <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready && mem_we_q) begin
                        pc_q       <= pc4_d;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc4_d;
                        retired_q  <= retired_q + RET_WIDTH'(1);
                        state_q    <= FETCH;
                    end else if (mem_ready) begin
                        res_q     <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= WB;
                    end
                end
                WB: begin
                    if (rd != 5'd0) regs_q[rd_idx] <= res_q;
                    if (rd == 5'd10) a0_q <= res_q;
                    pc_q       <= pc4_d;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= pc4_d;
                    retired_q  <= retired_q + RET_WIDTH'(1);
                    state_q    <= FETCH;
                end
                HALT:    state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign a0        = a0_q;
    assign halted    = halted_q;
    assign retired   = retired_q;
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and random programs checked against an instruction-level model.
module tb_multicycle_core;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req, mem_we, halted;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, a0, retired;
    logic [31:0] mem_rdata = '0;
    int          checks = 0, errors = 0;
    logic [31:0] mem [256];
    logic [31:0] mmem [256];
    logic [31:0] prog [$];
    logic [31:0] a0_seen [$];
    logic [31:0] a0_exp [$];
    logic [31:0] last_a0 = '0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic [31:0] sw_addr = '0, sw_data = '0, ret_at8 = '0;
    int          wait_n = 0, n_req = 0;

    multicycle_core dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .a0(a0), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_t(int rd, int rs1, int imm, logic [2:0] f3, logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] r_t(int rd, int rs1, int rs2, logic [6:0] f7);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] s_t(int rs2, int rs1, int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(logic [2:0] f3, int rs1, int rs2, int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), f3, o[4:1], o[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(int rd, int imm20);
        return {20'(imm20), 5'(rd), 7'h37};
    endfunction

    // Memory responder: fixed wait per transaction, optional permanent stall on one fetch address.
    initial begin
        bit          busy = 0, pend = 0;
        int          cnt = 0;
        logic [31:0] t_addr = '0, t_wdata = '0;
        logic        t_we = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (t_we) begin
                    mem[t_addr[9:2]] = t_wdata;
                    sw_addr = t_addr;
                    sw_data = t_wdata;
                end
                busy = 0;
                pend = 0;
            end
            if (mem_req) begin
                if (!busy) begin
                    busy = 1;
                    cnt = 0;
                    t_addr = mem_addr;
                    t_we = mem_we;
                    t_wdata = mem_wdata;
                    n_req++;
                end else begin
                    chk("stable_addr", mem_addr, t_addr);
                    chk("stable_we", 32'(mem_we), 32'(t_we));
                    if (t_we) chk("stable_wdata", mem_wdata, t_wdata);
                end
                mem_ready = (cnt >= wait_n) && !(mem_addr == stall_addr && !mem_we);
                mem_rdata = mem_ready ? mem[mem_addr[9:2]] : $urandom;
                pend = mem_ready && !rst;
                cnt++;
            end else begin
                busy = 0;
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (a0 !== last_a0) begin
            a0_seen.push_back(a0);
            last_a0 = a0;
        end
    end

    // Instruction-level reference: architectural effects plus cycle and transaction counts.
    task automatic model(input int w, output int e_ret, output int e_cyc, output int e_tx);
        logic [31:0] x [32];
        logic [31:0] pc, ir, a, b, v, addr, imm_i, imm_s, imm_b;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        int          rd;
        e_ret = 0;
        e_cyc = 0;
        e_tx = 0;
        pc = '0;
        a0_exp.delete();
        foreach (x[i]) x[i] = '0;
        for (int s = 0; s < 2000; s++) begin
            ir = mmem[pc[9:2]];
            op = ir[6:0];
            f3 = ir[14:12];
            f7 = ir[31:25];
            rd = int'(ir[11:7]);
            a = x[ir[19:15]];
            b = x[ir[24:20]];
            imm_i = {{20{ir[31]}}, ir[31:20]};
            imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            e_cyc += 1 + w;
            e_tx++;
            if (op == 7'h13 && f3 == 3'd0) begin
                v = a + imm_i;
                e_cyc += 3;
            end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
                v = a + b;
                e_cyc += 3;
            end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
                v = a - b;
                e_cyc += 3;
            end else if (op == 7'h37) begin
                v = {ir[31:12], 12'b0};
                e_cyc += 3;
            end else if (op == 7'h03 && f3 == 3'd2) begin
                addr = a + imm_i;
                e_cyc += 2;
                if (addr[1:0] != 2'b00) return;
                v = mmem[addr[9:2]];
                e_cyc += 2 + w;
                e_tx++;
            end else if (op == 7'h23 && f3 == 3'd2) begin
                addr = a + imm_s;
                e_cyc += 2;
                if (addr[1:0] != 2'b00) return;
                mmem[addr[9:2]] = b;
                e_cyc += 1 + w;
                e_tx++;
                e_ret++;
                pc += 4;
                continue;
            end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
                e_cyc += 2;
                e_ret++;
                pc = ((a == b) == (f3 == 3'd0)) ? pc + imm_b : pc + 4;
                continue;
            end else begin
                e_cyc += 1;
                return;
            end
            if (rd == 10 && v !== x[10]) a0_exp.push_back(v);
            if (rd != 0) x[rd] = v;
            e_ret++;
            pc += 4;
        end
    endtask

    task automatic run(input string name, input int w);
        int e_ret, e_cyc, e_tx, n, bad, idle;
        logic [31:0] ret_end;
        foreach (mem[i]) mem[i] = (i < 128) ? 32'h0000_007F : 32'(i) * 32'h9E37_79B9;
        foreach (prog[i]) mem[i] = prog[i];
        mmem = mem;
        model(w, e_ret, e_cyc, e_tx);
        wait_n = w;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a0_seen.delete();
        n_req = 0;
        chk({name, ":rst_req"}, 32'(mem_req), 0);
        chk({name, ":rst_halted"}, 32'(halted), 0);
        chk({name, ":rst_retired"}, retired, 0);
        chk({name, ":rst_a0"}, a0, 0);
        n = 0;
        while (!mem_req && n < 5) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 8) ret_at8 = retired;
        end
        chk({name, ":halted"}, 32'(halted), 1);
        chk({name, ":cycles"}, n, e_cyc);
        chk({name, ":retired"}, retired, e_ret);
        chk({name, ":n_req"}, n_req, e_tx);
        chk({name, ":a0_changes"}, a0_seen.size(), a0_exp.size());
        for (int i = 0; i < a0_seen.size() && i < a0_exp.size(); i++) chk({name, ":a0_seq"}, a0_seen[i], a0_exp[i]);
        bad = 0;
        foreach (mem[i]) if (mem[i] !== mmem[i]) bad++;
        chk({name, ":mem_words_bad"}, bad, 0);
        ret_end = retired;
        idle = 0;
        repeat (4) begin
            @(negedge clk);
            idle += int'(mem_req);
        end
        chk({name, ":halt_no_req"}, idle, 0);
        chk({name, ":halt_retired"}, retired, ret_end);
    endtask

    task automatic gen_random();
        int len;
        len = $urandom_range(10, 30);
        prog.delete();
        for (int i = 0; i < len; i++) begin
            int rd, rs1, rs2, k;
            k = $urandom_range(0, 9);
            rd = $urandom_range(0, 15);
            rs1 = $urandom_range(0, 15);
            rs2 = $urandom_range(0, 15);
            case (k)
                0, 1: prog.push_back(i_t(rd, rs1, $urandom_range(0, 4095) - 2048, 3'd0, 7'h13));
                2: prog.push_back(r_t(rd, rs1, rs2, 7'h00));
                3: prog.push_back(r_t(rd, rs1, rs2, 7'h20));
                4: prog.push_back(u_t(rd, $urandom));
                5: prog.push_back(s_t(rs2, 0, 512 + 4 * $urandom_range(0, 127)));
                6: prog.push_back(i_t(rd, 0, 512 + 4 * $urandom_range(0, 127), 3'd2, 7'h03));
                7: prog.push_back(b_t(3'($urandom_range(0, 1)), rs1, rs2, 4 * $urandom_range(2, 3)));
                8: prog.push_back(i_t(10, rs1, $urandom_range(0, 4095) - 2048, 3'd0, 7'h13));
                default: prog.push_back(r_t(10, rs1, rs2, 7'h00));
            endcase
        end
    endtask

    initial begin
        int n;
        prog.delete();
        prog.push_back(i_t(10, 0, 5, 3'd0, 7'h13));
        prog.push_back(i_t(10, 10, -7, 3'd0, 7'h13));
        run("p_addi", 0);
        chk("p_addi:ret_at8", ret_at8, 2);
        chk("p_addi:a0", a0, 32'hFFFF_FFFE);

        prog.delete();
        prog.push_back(i_t(1, 0, 3, 3'd0, 7'h13));
        prog.push_back(i_t(1, 1, -1, 3'd0, 7'h13));
        prog.push_back(b_t(3'd1, 1, 0, -4));
        run("p_loop", 0);
        chk("p_loop:retired", retired, 7);

        prog.delete();
        prog.push_back(i_t(10, 0, 32'h123, 3'd0, 7'h13));
        prog.push_back(b_t(3'd0, 0, 0, 8));
        prog.push_back(32'h0000_007F);
        prog.push_back(s_t(10, 0, 8));
        prog.push_back(i_t(11, 0, 8, 3'd2, 7'h03));
        prog.push_back(r_t(10, 11, 11, 7'h00));
        run("p_swlw", 2);
        chk("p_swlw:sw_addr", sw_addr, 8);
        chk("p_swlw:sw_data", sw_data, 32'h123);
        chk("p_swlw:a0", a0, 32'h246);

        prog.delete();
        prog.push_back(i_t(10, 0, 1, 3'd0, 7'h13));
        prog.push_back(i_t(1, 0, 6, 3'd2, 7'h03));
        run("p_misalign", 1);
        chk("p_misalign:retired", retired, 1);

        prog.delete();
        prog.push_back(32'h0000_007F);
        run("p_illegal", 0);
        chk("p_illegal:retired", retired, 0);

        prog.delete();
        prog.push_back(i_t(10, 0, 9, 3'd0, 7'h13));
        prog.push_back(r_t(10, 10, 10, 7'h01));
        run("p_badf7", 0);
        chk("p_badf7:a0", a0, 9);

        for (int t = 0; t < 10; t++) begin
            gen_random();
            run($sformatf("rand%0d", t), $urandom_range(0, 2));
        end

        // Reset pulsed while the second fetch is stalled.
        foreach (mem[i]) mem[i] = 32'h0000_007F;
        mem[0] = i_t(10, 0, 5, 3'd0, 7'h13);
        mem[1] = i_t(10, 0, 6, 3'd0, 7'h13);
        wait_n = 0;
        stall_addr = 32'h4;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!(mem_req && mem_addr == 32'h4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("stall:req", 32'(mem_req), 1);
        chk("stall:retired", retired, 1);
        chk("stall:a0", a0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stall_rst:req", 32'(mem_req), 0);
        chk("stall_rst:a0", a0, 0);
        chk("stall_rst:retired", retired, 0);
        chk("stall_rst:halted", 32'(halted), 0);
        @(negedge clk);
        chk("stall_rst:req_next", 32'(mem_req), 1);
        chk("stall_rst:addr_next", mem_addr, 0);
        stall_addr = 32'hFFFF_FFFF;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
